// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types, field positions and helper functions for the
//                MEM-stage load/store unit (access size, FSM states, funct3
//                decode, byte-mask generation and natural-alignment test).
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10,
      DONE = 2'b11
   } state_e;

   // funct3 layout: [1:0] access size, [2] unsigned load
   localparam int unsigned c_F3_SIZE_MSB = 1;
   localparam int unsigned c_F3_SIZE_LSB = 0;
   localparam int unsigned c_F3_UNSIGNED = 2;

   function automatic logic [7:0] size_mask(input size_e sz);
      logic [7:0] m;
      case (sz)
         SZ_B:    m = 8'h01;
         SZ_H:    m = 8'h03;
         SZ_W:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   function automatic logic is_aligned(input size_e sz, input logic [2:0] off);
      logic a;
      case (sz)
         SZ_B:    a = 1'b1;
         SZ_H:    a = (off[0] == 1'b0);
         SZ_W:    a = (off[1:0] == 2'b00);
         default: a = (off == 3'b000);
      endcase
      return a;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational lane steering. Store side: byte enables and
//                store data shifted to the byte offset. Load side: raw
//                doubleword shifted down, truncated to the access size and
//                sign/zero extended. Lanes past byte 7 are dropped.
//  Ports       : i_funct3 (size/unsigned), i_offset (addr[2:0]),
//                i_wdata (store data), i_rdata (raw read doubleword),
//                o_be (byte enables), o_wdata (lane-aligned store data),
//                o_ldata (extended load value)
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2:0]      i_funct3,
   input  logic [2:0]      i_offset,
   input  logic [XLEN-1:0] i_wdata,
   input  logic [XLEN-1:0] i_rdata,
   output logic [7:0]      o_be,
   output logic [XLEN-1:0] o_wdata,
   output logic [XLEN-1:0] o_ldata
);

   size_e           w_size;
   logic            w_unsigned;
   logic [15:0]     w_be_wide;
   logic [5:0]      w_bit_shift;
   logic [XLEN-1:0] w_rshift;

   assign w_size      = size_e'(i_funct3[c_F3_SIZE_MSB:c_F3_SIZE_LSB]);
   assign w_unsigned  = i_funct3[c_F3_UNSIGNED];
   assign w_bit_shift = {i_offset, 3'b000};

   // Shift in a 16-bit field so lanes above byte 7 fall off cleanly.
   assign w_be_wide = {8'h00, size_mask(w_size)} << i_offset;
   assign o_be      = w_be_wide[7:0];
   assign o_wdata   = i_wdata << w_bit_shift;
   assign w_rshift  = i_rdata >> w_bit_shift;

   always_comb begin
      o_ldata = w_rshift;
      case (w_size)
         SZ_B: o_ldata = {{(XLEN-8){w_rshift[7]  & ~w_unsigned}}, w_rshift[7:0]};
         SZ_H: o_ldata = {{(XLEN-16){w_rshift[15] & ~w_unsigned}}, w_rshift[15:0]};
         SZ_W: o_ldata = {{(XLEN-32){w_rshift[31] & ~w_unsigned}}, w_rshift[31:0]};
         default: o_ldata = w_rshift;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : MEM-stage stalling load/store unit for a 5-stage RV64
//                pipeline. Issues naturally aligned accesses over a
//                req/gnt/rvalid port, extends load data and registers the
//                writeback triple (rd, RegWrite, result) for WB.
//  Options     : LSU_MISALIGN_CHECK_EN - when defined, misaligned accesses
//                are not issued and raise misaligned_o for one cycle.
//  Ports       : clk_i, rst_ni (sync active-low)
//                ex_*   : EX-stage instruction fields
//                stall_o: freeze IF/ID/EX
//                dmem_* : data memory request/response port
//                mem_*  : registered writeback triple, misaligned_o flag
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int AW   = 64
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            ex_valid_i,
   input  logic            ex_MemRead_i,
   input  logic            ex_MemWrite_i,
   input  logic [2:0]      ex_funct3_i,
   input  logic [AW-1:0]   ex_addr_i,
   input  logic [XLEN-1:0] ex_wdata_i,
   input  logic [4:0]      ex_rd_i,
   input  logic            ex_RegWrite_i,
   input  logic [XLEN-1:0] ex_result_i,
   output logic            stall_o,
   output logic            dmem_req_o,
   output logic            dmem_we_o,
   output logic [AW-1:0]   dmem_addr_o,
   output logic [7:0]      dmem_be_o,
   output logic [XLEN-1:0] dmem_wdata_o,
   input  logic            dmem_gnt_i,
   input  logic            dmem_rvalid_i,
   input  logic [XLEN-1:0] dmem_rdata_i,
   output logic [4:0]      mem_rd_o,
   output logic            mem_RegWrite_o,
   output logic [XLEN-1:0] mem_result_o,
   output logic            misaligned_o
);

   state_e          r_state, w_next;
   logic [AW-1:0]   r_addr;
   logic            r_we;
   logic [2:0]      r_funct3;
   logic [4:0]      r_rd;
   logic            r_regwrite;
   logic [7:0]      r_be;
   logic [XLEN-1:0] r_wdata;
   logic [XLEN-1:0] r_ldbuf;
   logic [4:0]      r_mem_rd;
   logic            r_mem_regwrite;
   logic [XLEN-1:0] r_mem_result;
   logic            r_misaligned;

   logic            w_mem_op;
   logic            w_trap;
   logic            w_stall;
   logic [2:0]      w_sel_f3;
   logic [2:0]      w_sel_off;
   logic [7:0]      w_be;
   logic [XLEN-1:0] w_wdata;
   logic [XLEN-1:0] w_ldata;

   assign w_mem_op = ex_valid_i & (ex_MemRead_i | ex_MemWrite_i);

`ifdef LSU_MISALIGN_CHECK_EN
   assign w_trap = w_mem_op &
                   ~is_aligned(size_e'(ex_funct3_i[c_F3_SIZE_MSB:c_F3_SIZE_LSB]),
                               ex_addr_i[2:0]);
`else
   assign w_trap = 1'b0;
`endif

   // One aligner serves both paths: in IDLE it shapes the outgoing store
   // from EX fields; afterwards it decodes the response using the latches.
   assign w_sel_f3  = (r_state == IDLE) ? ex_funct3_i    : r_funct3;
   assign w_sel_off = (r_state == IDLE) ? ex_addr_i[2:0] : r_addr[2:0];

   lsu_align #(.XLEN(XLEN)) u_align (
      .i_funct3 (w_sel_f3),
      .i_offset (w_sel_off),
      .i_wdata  (ex_wdata_i),
      .i_rdata  (dmem_rdata_i),
      .o_be     (w_be),
      .o_wdata  (w_wdata),
      .o_ldata  (w_ldata)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_stall = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_mem_op && !w_trap) begin
               w_stall = 1'b1;
               w_next  = REQ;
            end
         end
         REQ: begin
            w_stall = 1'b1;
            if (dmem_gnt_i) w_next = r_we ? DONE : WAIT;
         end
         WAIT: begin
            w_stall = 1'b1;
            if (dmem_rvalid_i) w_next = DONE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Request and load-buffer latches
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_addr     <= '0;
         r_we       <= 1'b0;
         r_funct3   <= '0;
         r_rd       <= '0;
         r_regwrite <= 1'b0;
         r_be       <= '0;
         r_wdata    <= '0;
         r_ldbuf    <= '0;
      end else begin
         if (r_state == IDLE && w_mem_op && !w_trap) begin
            r_addr     <= ex_addr_i;
            r_we       <= ex_MemWrite_i;
            r_funct3   <= ex_funct3_i;
            r_rd       <= ex_rd_i;
            r_regwrite <= ex_RegWrite_i & ~ex_MemWrite_i;
            r_be       <= w_be;
            r_wdata    <= w_wdata;
         end
         if (r_state == WAIT && dmem_rvalid_i) r_ldbuf <= w_ldata;
      end
   end

   // Writeback register: bubble while stalled, memory result in DONE,
   // otherwise pass the EX triple straight through.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_mem_rd       <= '0;
         r_mem_regwrite <= 1'b0;
         r_mem_result   <= '0;
         r_misaligned   <= 1'b0;
      end else if (w_stall) begin
         r_mem_rd       <= '0;
         r_mem_regwrite <= 1'b0;
         r_mem_result   <= '0;
         r_misaligned   <= 1'b0;
      end else if (r_state == DONE) begin
         r_mem_rd       <= r_rd;
         r_mem_regwrite <= r_regwrite;
         r_mem_result   <= r_we ? '0 : r_ldbuf;
         r_misaligned   <= 1'b0;
      end else if (w_trap) begin
         r_mem_rd       <= ex_rd_i;
         r_mem_regwrite <= 1'b0;
         r_mem_result   <= '0;
         r_misaligned   <= 1'b1;
      end else begin
         r_mem_rd       <= ex_rd_i;
         r_mem_regwrite <= ex_RegWrite_i & ex_valid_i;
         r_mem_result   <= ex_result_i;
         r_misaligned   <= 1'b0;
      end
   end

   assign stall_o        = w_stall;
   assign dmem_req_o     = (r_state == REQ);
   assign dmem_we_o      = r_we;
   assign dmem_addr_o    = {r_addr[AW-1:3], 3'b000};
   assign dmem_be_o      = r_be;
   assign dmem_wdata_o   = r_wdata;
   assign mem_rd_o       = r_mem_rd;
   assign mem_RegWrite_o = r_mem_regwrite;
   assign mem_result_o   = r_mem_result;
   assign misaligned_o   = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Directed self-checking bench for load_store_unit. Covers
//                reset, pass-through, loads of every size/sign, a stalled
//                store, reset during WAIT and the misalignment option
//                (LSU_MISALIGN_CHECK_EN selects which variant is checked).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        ex_valid_i, ex_MemRead_i, ex_MemWrite_i, ex_RegWrite_i;
   logic [2:0]  ex_funct3_i;
   logic [63:0] ex_addr_i, ex_wdata_i, ex_result_i;
   logic [4:0]  ex_rd_i;
   logic        stall_o, dmem_req_o, dmem_we_o;
   logic [63:0] dmem_addr_o, dmem_wdata_o;
   logic [7:0]  dmem_be_o;
   logic        dmem_gnt_i, dmem_rvalid_i;
   logic [63:0] dmem_rdata_i;
   logic [4:0]  mem_rd_o;
   logic        mem_RegWrite_o;
   logic [63:0] mem_result_o;
   logic        misaligned_o;

   int n_checks = 0;
   int n_errors = 0;
   int stall_cnt;

   always #5 clk_i = ~clk_i;

   load_store_unit #(.XLEN(64), .AW(64)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .ex_valid_i(ex_valid_i), .ex_MemRead_i(ex_MemRead_i),
      .ex_MemWrite_i(ex_MemWrite_i), .ex_funct3_i(ex_funct3_i),
      .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i), .ex_rd_i(ex_rd_i),
      .ex_RegWrite_i(ex_RegWrite_i), .ex_result_i(ex_result_i),
      .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
      .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
      .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
      .mem_rd_o(mem_rd_o), .mem_RegWrite_o(mem_RegWrite_o),
      .mem_result_o(mem_result_o), .misaligned_o(misaligned_o)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic ex_clear();
      ex_valid_i = 0; ex_MemRead_i = 0; ex_MemWrite_i = 0; ex_RegWrite_i = 0;
      ex_funct3_i = 0; ex_addr_i = 0; ex_wdata_i = 0; ex_rd_i = 0; ex_result_i = 0;
   endtask

   // Load with gnt in the first REQ cycle and rvalid in the first WAIT cycle.
   task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] rdata, input logic [7:0] exp_be,
                          input logic [63:0] exp_res);
      ex_valid_i = 1; ex_MemRead_i = 1; ex_MemWrite_i = 0; ex_RegWrite_i = 1;
      ex_funct3_i = f3; ex_addr_i = addr; ex_rd_i = 5'd9; ex_result_i = 64'h5555;
      #1;
      chk({tag, "_stall_idle"}, {63'd0, stall_o}, 64'd1);
      step();                                   // REQ
      chk({tag, "_req"},  {63'd0, dmem_req_o}, 64'd1);
      chk({tag, "_addr"}, dmem_addr_o, {addr[63:3], 3'b000});
      chk({tag, "_be"},   {56'd0, dmem_be_o}, {56'd0, exp_be});
      dmem_gnt_i = 1;
      step();                                   // WAIT
      dmem_gnt_i = 0;
      chk({tag, "_wait_noreq"}, {63'd0, dmem_req_o}, 64'd0);
      dmem_rvalid_i = 1; dmem_rdata_i = rdata;
      step();                                   // DONE
      dmem_rvalid_i = 0; dmem_rdata_i = 64'hDEAD_0000_DEAD_0000;
      chk({tag, "_done_nostall"}, {63'd0, stall_o}, 64'd0);
      step();                                   // back to IDLE, result visible
      ex_clear();
      #1;
      chk({tag, "_rd"},  {59'd0, mem_rd_o}, 64'd9);
      chk({tag, "_rw"},  {63'd0, mem_RegWrite_o}, 64'd1);
      chk({tag, "_res"}, mem_result_o, exp_res);
   endtask

   initial begin
      rst_ni = 0; ex_clear();
      dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
      step(); step();
      chk("rst_rd",    {59'd0, mem_rd_o}, 64'd0);
      chk("rst_rw",    {63'd0, mem_RegWrite_o}, 64'd0);
      chk("rst_res",   mem_result_o, 64'd0);
      chk("rst_stall", {63'd0, stall_o}, 64'd0);
      chk("rst_req",   {63'd0, dmem_req_o}, 64'd0);
      chk("rst_mis",   {63'd0, misaligned_o}, 64'd0);
      rst_ni = 1;
      step();

      // ADD pass-through
      ex_valid_i = 1; ex_RegWrite_i = 1; ex_rd_i = 5'd5; ex_result_i = 64'h1234;
      #1;
      chk("add_stall", {63'd0, stall_o}, 64'd0);
      step();
      chk("add_rd",  {59'd0, mem_rd_o}, 64'd5);
      chk("add_rw",  {63'd0, mem_RegWrite_o}, 64'd1);
      chk("add_res", mem_result_o, 64'h1234);
      // RegWrite gated by valid
      ex_valid_i = 0;
      step();
      chk("inval_rw", {63'd0, mem_RegWrite_o}, 64'd0);
      ex_clear();

      do_load("lb",  3'b000, 64'h13, 64'h0000_8000_0000_0000, 8'h08, 64'h0);
      do_load("lb2", 3'b000, 64'h13, 64'h0000_0000_AB00_0000, 8'h08, 64'hFFFF_FFFF_FFFF_FFAB);
      do_load("lbu", 3'b100, 64'h13, 64'h0000_0000_AB00_0000, 8'h08, 64'h0000_0000_0000_00AB);
      do_load("lh",  3'b001, 64'h16, 64'h8001_0000_0000_0000, 8'hC0, 64'hFFFF_FFFF_FFFF_8001);
      do_load("lhu", 3'b101, 64'h16, 64'h8001_0000_0000_0000, 8'hC0, 64'h0000_0000_0000_8001);
      do_load("lw",  3'b010, 64'h04, 64'h8000_0000_1234_5678, 8'hF0, 64'hFFFF_FFFF_8000_0000);
      do_load("lwu", 3'b110, 64'h04, 64'h8000_0000_1234_5678, 8'hF0, 64'h0000_0000_8000_0000);
      do_load("ld",  3'b011, 64'h08, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF);
      do_load("ldu", 3'b111, 64'h18, 64'hFEDC_BA98_7654_3210, 8'hFF, 64'hFEDC_BA98_7654_3210);

      // SW at 0x24 with gnt held off for three REQ cycles
      stall_cnt = 0;
      ex_valid_i = 1; ex_MemWrite_i = 1; ex_funct3_i = 3'b010; ex_addr_i = 64'h24;
      ex_wdata_i = 64'hDEAD_BEEF; ex_rd_i = 5'd0; ex_RegWrite_i = 0;
      #1;
      if (stall_o) stall_cnt++;
      step();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) dmem_gnt_i = 1;
         #1;
         chk("sw_req",   {63'd0, dmem_req_o}, 64'd1);
         chk("sw_we",    {63'd0, dmem_we_o}, 64'd1);
         chk("sw_addr",  dmem_addr_o, 64'h20);
         chk("sw_be",    {56'd0, dmem_be_o}, 64'hF0);
         chk("sw_wdata", dmem_wdata_o, 64'hDEAD_BEEF_0000_0000);
         if (stall_o) stall_cnt++;
         step();
      end
      dmem_gnt_i = 0;
      #1;
      if (stall_o) stall_cnt++;
      chk("sw_done_req", {63'd0, dmem_req_o}, 64'd0);
      step();
      ex_clear();
      #1;
      chk("sw_stall_cycles", stall_cnt, 64'd5);
      chk("sw_rw", {63'd0, mem_RegWrite_o}, 64'd0);
      chk("sw_res", mem_result_o, 64'd0);

      // LD, reset while waiting, rvalid arrives just after reset
      ex_valid_i = 1; ex_MemRead_i = 1; ex_funct3_i = 3'b011; ex_addr_i = 64'h40;
      ex_rd_i = 5'd12; ex_RegWrite_i = 1;
      step();                                   // REQ
      dmem_gnt_i = 1;
      step();                                   // WAIT
      dmem_gnt_i = 0;
      rst_ni = 0;
      step();                                   // reset edge
      rst_ni = 1; ex_clear();
      dmem_rvalid_i = 1; dmem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      chk("rstw_stall", {63'd0, stall_o}, 64'd0);
      chk("rstw_req",   {63'd0, dmem_req_o}, 64'd0);
      chk("rstw_rw",    {63'd0, mem_RegWrite_o}, 64'd0);
      chk("rstw_be",    {56'd0, dmem_be_o}, 64'd0);
      step();
      dmem_rvalid_i = 0;
      chk("rstw_rw2",  {63'd0, mem_RegWrite_o}, 64'd0);
      chk("rstw_rd2",  {59'd0, mem_rd_o}, 64'd0);
      chk("rstw_res2", mem_result_o, 64'd0);
      chk("rstw_stall2", {63'd0, stall_o}, 64'd0);
      step();
      chk("rstw_rw3",  {63'd0, mem_RegWrite_o}, 64'd0);

`ifdef LSU_MISALIGN_CHECK_EN
      ex_valid_i = 1; ex_MemRead_i = 1; ex_funct3_i = 3'b010; ex_addr_i = 64'h22;
      ex_rd_i = 5'd3; ex_RegWrite_i = 1;
      #1;
      chk("mis_stall", {63'd0, stall_o}, 64'd0);
      chk("mis_req",   {63'd0, dmem_req_o}, 64'd0);
      step();
      ex_clear();
      #1;
      chk("mis_flag",  {63'd0, misaligned_o}, 64'd1);
      chk("mis_rw",    {63'd0, mem_RegWrite_o}, 64'd0);
      chk("mis_req2",  {63'd0, dmem_req_o}, 64'd0);
      step();
      chk("mis_flag2", {63'd0, misaligned_o}, 64'd0);
      chk("mis_req3",  {63'd0, dmem_req_o}, 64'd0);
`else
      // Unchecked misaligned LW at 0x22 issues with its offset honoured
      ex_valid_i = 1; ex_MemRead_i = 1; ex_funct3_i = 3'b010; ex_addr_i = 64'h22;
      ex_rd_i = 5'd3; ex_RegWrite_i = 1;
      #1;
      chk("lw22_stall", {63'd0, stall_o}, 64'd1);
      step();
      chk("lw22_be", {56'd0, dmem_be_o}, 64'h3C);
      chk("lw22_mis", {63'd0, misaligned_o}, 64'd0);
      dmem_gnt_i = 1;
      step();
      dmem_gnt_i = 0;
      dmem_rvalid_i = 1; dmem_rdata_i = 64'h0000_0000_8765_0000;
      step();
      dmem_rvalid_i = 0;
      step();
      ex_clear();
      #1;
      chk("lw22_res", mem_result_o, 64'h0000_0000_0000_8765);
      // LD at 0x0C: lanes above byte 7 dropped, upper bytes read as zero
      do_load("ld0c", 3'b011, 64'h0C, 64'h1122_3344_5566_7788, 8'hF0, 64'h0000_0000_1122_3344);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Safety net against an unexpected hang
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Fills the MEM slot between EX and WB of the 5-stage RV64 pipeline.
- Replaces the plain mem_rd/mem_RegWrite/mem_result pipeline register with a stalling load/store unit.
- Issues naturally aligned LB/LH/LW/LD(U) and SB/SH/SW/SD to a data memory port over a req/gnt/rvalid handshake.
- Aligns and extends load data, and presents the MEM-stage writeback triple to WB.

Parameters:
- XLEN, 64, datapath width; the only supported value is 64.
- AW, 64, byte address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- ex_valid_i  in  1  EX holds a valid instruction.
- ex_MemRead_i  in  1  EX instruction is a load.
- ex_MemWrite_i  in  1  EX instruction is a store.
- ex_funct3_i  in  3  [1:0] size (00 B, 01 H, 10 W, 11 D); [2] unsigned load.
- ex_addr_i  in  AW  effective address (ALU result).
- ex_wdata_i  in  XLEN  store data (rs2 value).
- ex_rd_i  in  5  destination register.
- ex_RegWrite_i  in  1  writeback enable.
- ex_result_i  in  XLEN  non-memory EX result.
- stall_o  out  1  freeze IF/ID/EX this cycle.
- dmem_req_o  out  1  memory request valid.
- dmem_we_o  out  1  request is a write.
- dmem_addr_o  out  AW  address, with [2:0] forced to 0.
- dmem_be_o  out  8  byte enables.
- dmem_wdata_o  out  XLEN  lane-aligned store data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  XLEN  raw 64-bit read doubleword.
- mem_rd_o  out  5  registered destination register.
- mem_RegWrite_o  out  1  registered writeback enable.
- mem_result_o  out  XLEN  registered writeback value.
- misaligned_o  out  1  registered misaligned-access flag.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - state=IDLE.
  - All mem_* outputs, misaligned_o and the internal request/data latches are 0.
  - dmem_req_o=0 and stall_o=0 from the following cycle.
  - Reset in any state abandons the access. A late dmem_gnt_i/dmem_rvalid_i after reset is ignored.
- Memory op: mem_op = ex_valid_i & (ex_MemRead_i | ex_MemWrite_i).
- Output register: mem_* update on every edge with stall_o=0. On edges with stall_o=1 they load a bubble (mem_RegWrite_o=0, mem_rd_o=0, mem_result_o=0).
- Non-memory instruction in IDLE:
  - mem_rd_o/mem_RegWrite_o/mem_result_o take the ex_* values next edge (1-cycle latency).
  - ex_RegWrite_i is gated by ex_valid_i.
- State machine:
  - IDLE:
    - mem_op & aligned → stall_o=1. Latch addr, we, funct3, rd, RegWrite, computed be/wdata. Go to REQ.
    - mem_op & misaligned → see Optional Feature.
  - REQ:
    - dmem_req_o=1, stall_o=1. Request fields are held stable until gnt.
    - gnt & we → DONE. gnt & ~we → WAIT. Otherwise stay in REQ.
  - WAIT:
    - stall_o=1, dmem_req_o=0.
    - On dmem_rvalid_i: extract the lane at byte offset addr[2:0], extend, latch into the load buffer, go to DONE.
  - DONE:
    - stall_o=0. mem_* load the latched rd/RegWrite; mem_result_o takes the load buffer (loads) or 0 (stores, RegWrite=0).
    - Next state is IDLE.
    - EX advances at this same edge, so a back-to-back memory op is first seen in IDLE on the following cycle.
- Memory protocol rules:
  - dmem_rvalid_i is ignored outside WAIT.
  - Memory never asserts rvalid in the gnt cycle.
  - Minimum load latency is 4 cycles (IDLE, REQ, WAIT, DONE); minimum store latency is 3.
- Byte lanes:
  - Size mask: B=0x01, H=0x03, W=0x0F, D=0xFF.
  - dmem_be_o = mask << addr[2:0].
  - dmem_wdata_o = ex_wdata_i << (8*addr[2:0]).
- Load extraction: data = dmem_rdata_i >> (8*addr[2:0]), truncated to the access size. funct3[2]=0 sign-extends to 64; funct3[2]=1 zero-extends.
- Alignment:
  - Naturally aligned means H: addr[0]=0; W: addr[1:0]=0; D: addr[2:0]=0. B is always aligned.
  - funct3=111 (LDU, illegal) is treated as D, zero-extended.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined:
  - A misaligned mem_op in IDLE issues no request and raises no stall.
  - Next edge: misaligned_o=1 for one cycle, mem_RegWrite_o=0.
- Undefined:
  - No check is made; misaligned_o is tied 0.
  - The access issues with the address's low bits honoured. Lanes beyond byte 7 are dropped, giving truncated be/wdata; loads read the upper bytes as 0.

Decomposition:
- Package lsu_pkg:
  - Size enum (SZ_B/H/W/D).
  - State enum (IDLE/REQ/WAIT/DONE).
  - funct3 field constants.
  - Functions size_mask() and is_aligned().
- Sub-module lsu_align: combinational store lane shift/be generation plus load extract/extend. It is shared between issue and response paths.

Test Plan:
- ADD with ex_result_i=0x1234, rd=5 → next edge mem_rd_o=5, mem_RegWrite_o=1, mem_result_o=0x1234, stall_o never asserted.
- LB at addr 0x13 with rdata=0x0000_8000_0000_0000, gnt in REQ cycle, rvalid next cycle:
  - dmem_addr_o=0x10, dmem_be_o=0x08.
  - Byte lane 3 of rdata is 0x00, so mem_result_o=0x0000_0000_0000_0000.
- LH at addr 0x16 with rdata=0x8001_0000_0000_0000 → mem_result_o=0xFFFF_FFFF_FFFF_8001. LHU at the same address → 0x8001.
- SW at 0x24, wdata=0xDEADBEEF, gnt delayed 3 cycles:
  - dmem_be_o=0xF0 and dmem_wdata_o=0xDEADBEEF_0000_0000, both held stable while gnt=0.
  - stall_o=1 for 5 cycles, then mem_RegWrite_o=0.
- LD issued, rst_ni=0 in WAIT, rvalid arrives the cycle after reset → state IDLE, all outputs 0, rvalid ignored, no writeback.
- With LSU_MISALIGN_CHECK_EN, LW at 0x22 → dmem_req_o stays 0, misaligned_o=1 for exactly one cycle, mem_RegWrite_o=0.
